// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants, register offsets and byte-merge helper for irq_ctrl.
package irq_ctrl_pkg;
    localparam int IRQ_MEIP_BIT = 11;
    typedef enum logic [3:0] {
        IRQC_PENDING = 4'h0,
        IRQC_ENABLE  = 4'h4,
        IRQC_EDGE    = 4'h8,
        IRQC_CLAIM   = 4'hC
    } irqc_reg_e;
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: load/store register window bus between core and irq_ctrl.
interface irq_ctrl_if;
    logic        sel;
    logic        read;
    logic [3:0]  write;
    logic [3:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    modport master (output sel, read, write, address, data_in, input data_out);
    modport slave  (input sel, read, write, address, data_in, output data_out);
endinterface

// File: rtl/irq_gateway.sv
// irq_gateway: per-source sampling and pending latch; IRQ_SYNC_EN adds a 2-flop synchronizer.
module irq_gateway (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic edge_mode,
    input  logic in_service,
    input  logic claim,
    output logic pending
);
    logic s, src_prev;
`ifdef IRQ_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= '0;
        else sync <= {sync[0], src};
    assign s = sync[1];
`else
    assign s = src;
`endif
    // A fresh edge outranks a claim clearing the same source.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            src_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            src_prev <= s;
            pending  <= edge_mode ? (s & ~src_prev) | (pending & ~claim) : s & ~in_service;
        end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller with PENDING/ENABLE/EDGE/CLAIM window driving MEIP.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter int IRQ_BIT = IRQ_MEIP_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    irq_ctrl_if.slave        bus,
    output logic [31:0]      IRQ
);
    logic [N_SRC-1:0] pending, enable, edge_cfg, in_service, claimable, claim_oh, comp_oh;
    logic [4:0]  id;
    logic [31:0] rd_val;
    logic        rd, wr, irq_q, unused_addr;
    irqc_reg_e   reg_sel;
    assign unused_addr = ^bus.address[1:0];
    assign reg_sel   = irqc_reg_e'({bus.address[3:2], 2'b00});
    assign rd        = bus.sel & bus.read;
    assign wr        = bus.sel & ~bus.read;
    assign claimable = pending & enable & ~in_service;
    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        id       = '0;
        claim_oh = '0;
        comp_oh  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) id = claimable[i] ? 5'(i + 1) : id;
        for (int i = 0; i < N_SRC; i++) begin
            claim_oh[i] = rd && reg_sel == IRQC_CLAIM && id == 5'(i + 1);
            comp_oh[i]  = wr && bus.write[0] && reg_sel == IRQC_CLAIM && bus.data_in[4:0] == 5'(i + 1);
        end
    end
    assign rd_val = reg_sel == IRQC_PENDING ? 32'(pending) :
                    reg_sel == IRQC_ENABLE  ? 32'(enable)  :
                    reg_sel == IRQC_EDGE    ? 32'(edge_cfg) : 32'(id);
    for (genvar g = 0; g < N_SRC; g++) begin : gw
        irq_gateway u_gw (
            .clk        (clk),
            .reset      (reset),
            .src        (irq_src[g]),
            .edge_mode  (edge_cfg[g]),
            .in_service (in_service[g]),
            .claim      (claim_oh[g]),
            .pending    (pending[g])
        );
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            enable       <= '0;
            edge_cfg     <= '0;
            in_service   <= '0;
            bus.data_out <= '0;
            irq_q        <= 1'b0;
        end else begin
            if (wr && reg_sel == IRQC_ENABLE) enable <= N_SRC'(byte_merge(32'(enable), bus.data_in, bus.write));
            if (wr && reg_sel == IRQC_EDGE) edge_cfg <= N_SRC'(byte_merge(32'(edge_cfg), bus.data_in, bus.write));
            in_service <= (in_service | claim_oh) & ~comp_oh;
            if (rd) bus.data_out <= rd_val;
            irq_q <= |claimable;
        end
    assign IRQ = 32'(irq_q) << IRQ_BIT;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (default build, IRQ_SYNC_EN undefined).
module tb_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_src = '0;
    logic [31:0] irq;
    logic [31:0] v;
    int          passed = 0;
    int          total = 0;
    irq_ctrl_if bus();
    irq_ctrl #(.N_SRC(8), .IRQ_BIT(11)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus),
        .IRQ     (irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic idle();
        bus.sel = 0; bus.read = 0; bus.write = 0;
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.sel = 1; bus.write = be; bus.address = a; bus.data_in = d;
        @(negedge clk);
        idle();
    endtask
    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.sel = 1; bus.read = 1; bus.address = a;
        @(negedge clk);
        idle();
        check(tag, bus.data_out, exp);
    endtask
    task automatic pulse(input int k);
        @(negedge clk);
        irq_src[k] = 1'b1;
        @(negedge clk);
        irq_src[k] = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        idle();
        bus.address = '0; bus.data_in = '0;
        #3;
        check("rst_irq", irq, 32'h0);
        check("rst_dout", bus.data_out, 32'h0);
        @(negedge clk); reset = 0;
        // build up state, then reset asynchronously mid-cycle
        wr(4'h4, 32'hFF, 4'hF);
        rd_chk("enable_ff", 4'h4, 32'hFF);
        irq_src[0] = 1;
        repeat (2) @(negedge clk);
        check("level_irq", irq, 32'h800);
        #2 reset = 1;
        #1;
        check("async_irq", irq, 32'h0);
        check("async_dout", bus.data_out, 32'h0);
        irq_src = '0;
        @(negedge clk); reset = 0;
        rd_chk("rst_pending", 4'h0, 32'h0);
        rd_chk("rst_enable", 4'h4, 32'h0);
        rd_chk("rst_edge", 4'h8, 32'h0);
        // edge claim flow
        wr(4'h8, 32'h1, 4'hF);
        wr(4'h4, 32'h1, 4'hF);
        pulse(0);
        check("edge_irq_lat", irq, 32'h0);
        @(negedge clk);
        check("edge_irq", irq, 32'h800);
        rd_chk("edge_claim", 4'hC, 32'h1);
        @(negedge clk);
        check("edge_irq_drop", irq, 32'h0);
        rd_chk("edge_pend_clr", 4'h0, 32'h0);
        pulse(0);
        rd_chk("edge_pend_insvc", 4'h0, 32'h1);
        check("edge_irq_insvc", irq, 32'h0);
        wr(4'hC, 32'h1, 4'h1);
        check("cmpl_irq_lat", irq, 32'h0);
        @(negedge clk);
        check("cmpl_irq", irq, 32'h800);
        rd_chk("edge_claim2", 4'hC, 32'h1);
        wr(4'hC, 32'h1, 4'h1);
        // priority among level sources 2, 5, 7
        wr(4'h8, 32'h0, 4'hF);
        wr(4'h4, 32'hFF, 4'hF);
        irq_src = 8'h52;
        repeat (2) @(negedge clk);
        rd_chk("prio_2", 4'hC, 32'd2);
        rd_chk("prio_5", 4'hC, 32'd5);
        rd_chk("prio_7", 4'hC, 32'd7);
        rd_chk("prio_0", 4'hC, 32'd0);
        check("prio_irq", irq, 32'h0);
        irq_src = '0;
        @(negedge clk);
        wr(4'hC, 32'd2, 4'h1);
        wr(4'hC, 32'd5, 4'h1);
        wr(4'hC, 32'd7, 4'h1);
        @(negedge clk);
        check("prio_idle_irq", irq, 32'h0);
        // level drop before claim
        irq_src[2] = 1;
        repeat (2) @(negedge clk);
        rd_chk("lvl_pend", 4'h0, 32'h4);
        check("lvl_irq", irq, 32'h800);
        irq_src[2] = 0;
        @(negedge clk);
        rd_chk("lvl_pend_drop", 4'h0, 32'h0);
        rd_chk("lvl_claim0", 4'hC, 32'h0);
        @(negedge clk);
        check("lvl_irq_drop", irq, 32'h0);
        // byte-granular writes and masking
        wr(4'h4, 32'h0, 4'hF);
        wr(4'h4, 32'hFFFFFFFF, 4'h2);
        rd_chk("byte1_masked", 4'h4, 32'h0);
        wr(4'h4, 32'hFFFFFFA5, 4'h1);
        rd_chk("byte0_only", 4'h4, 32'hA5);
        wr(4'h5, 32'hFFFFFFFF, 4'hF);
        rd_chk("edge_mask_addr_lsb", 4'h8, 32'h0);
        rd_chk("enable_masked", 4'h4, 32'hFF);
        wr(4'h8, 32'hFFFFFFFF, 4'hF);
        rd_chk("edge_masked", 4'h8, 32'hFF);
        // bad completes leave in_service untouched
        wr(4'h4, 32'h1, 4'hF);
        pulse(0);
        rd_chk("bad_claim", 4'hC, 32'h1);
        pulse(0);
        rd_chk("bad_pend", 4'h0, 32'h1);
        wr(4'h0, 32'h0, 4'hF);
        rd_chk("pend_ro", 4'h0, 32'h1);
        wr(4'hC, 32'd0, 4'h1);
        wr(4'hC, 32'd9, 4'h1);
        @(negedge clk);
        check("bad_cmpl_irq", irq, 32'h0);
        wr(4'hC, 32'd1, 4'h2);
        @(negedge clk);
        check("cmpl_no_b0", irq, 32'h0);
        wr(4'hC, 32'd1, 4'h1);
        @(negedge clk);
        check("good_cmpl_irq", irq, 32'h800);
        // set-wins race: edge arrives in the claim cycle
        @(negedge clk);
        bus.sel = 1; bus.read = 1; bus.address = 4'hC;
        irq_src[0] = 1;
        @(negedge clk);
        idle();
        irq_src[0] = 0;
        check("race_claim", bus.data_out, 32'h1);
        rd_chk("race_pend", 4'h0, 32'h1);
        // read wins over simultaneous write; sel=0 ignored
        @(negedge clk);
        bus.sel = 1; bus.read = 1; bus.write = 4'hF; bus.address = 4'h4; bus.data_in = 32'h0;
        @(negedge clk);
        idle();
        check("rw_read", bus.data_out, 32'h1);
        rd_chk("rw_no_write", 4'h4, 32'h1);
        @(negedge clk);
        bus.sel = 0; bus.write = 4'hF; bus.address = 4'h4; bus.data_in = 32'h0;
        @(negedge clk);
        idle();
        rd_chk("nosel_no_write", 4'h4, 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
